// File: rtl/dpram_arbiter_pkg.sv
// Shared constants for the dual-port RAM arbiter and its round-robin sub-arbiters.
package dpram_arbiter_pkg;

    localparam int BYTE_LANES = 4;
    localparam int MAX_REQ    = 4;
    localparam int REQ_IDX_W  = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer and grants one requester.
// The pointer only advances when the caller accepts the grant.
module rr_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic                 accept_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 valid_o,
    output logic [REQ_IDX_W-1:0] idx_o
);

    logic [REQ_IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int cand;
        cand    = 0;
        grant_o = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = REQ_IDX_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && valid_o) begin
            ptr_d = (int'(idx_o) == NUM_REQ - 1) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dual-port RAM between NUM_REQ requesters: independent read/write
// round-robin arbitration, same-address hazard stalls and read-response routing.
module dpram_arbiter
    import dpram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ-1:0]               req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]    req_wdata_i,
    input  logic [NUM_REQ*BYTE_LANES-1:0]    req_bytemask_i,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [WORD_WIDTH-1:0]            rsp_rdata_o,
    output logic                             ram_rclke_o,
    output logic                             ram_re_o,
    output logic [ADDR_WIDTH-1:0]            ram_raddr_o,
    output logic                             ram_wclke_o,
    output logic                             ram_we_o,
    output logic [ADDR_WIDTH-1:0]            ram_waddr_o,
    output logic [WORD_WIDTH-1:0]            ram_wdata_o,
    output logic [BYTE_LANES-1:0]            ram_wbytemask_o,
    input  logic [WORD_WIDTH-1:0]            ram_rdata_i,
    output logic [CNT_WIDTH-1:0]             stall_cnt_o
);

    logic [NUM_REQ-1:0]    rd_cand, wr_cand;
    logic [NUM_REQ-1:0]    rd_grant, wr_grant;
    logic                  rd_found, wr_found;
    logic [REQ_IDX_W-1:0]  rd_idx, wr_idx;
    logic                  rd_take, wr_take, hazard;
    logic [ADDR_WIDTH-1:0] raddr, waddr;
    logic [WORD_WIDTH-1:0] wdata;
    logic [BYTE_LANES-1:0] wmask;

    logic                  rsp_pend_q;
    logic [REQ_IDX_W-1:0]  rd_id_q;
    logic                  hazard_q;
    logic [ADDR_WIDTH-1:0] hazard_addr_q;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;

    // Writes to the address a read just stalled on sit out one cycle so the read wins.
    always_comb begin
        rd_cand = '0;
        wr_cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_cand[i] = req_valid_i[i] && !req_we_i[i];
            wr_cand[i] = req_valid_i[i] && req_we_i[i] &&
                         !(hazard_q && (req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == hazard_addr_q));
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (rd_cand),
        .accept_i (rd_take),
        .grant_o  (rd_grant),
        .valid_o  (rd_found),
        .idx_o    (rd_idx)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (wr_cand),
        .accept_i (wr_take),
        .grant_o  (wr_grant),
        .valid_o  (wr_found),
        .idx_o    (wr_idx)
    );

    always_comb begin
        raddr = '0;
        waddr = '0;
        wdata = '0;
        wmask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_grant[i]) raddr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (wr_grant[i]) begin
                waddr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata = req_wdata_i[i*WORD_WIDTH +: WORD_WIDTH];
                wmask = req_bytemask_i[i*BYTE_LANES +: BYTE_LANES];
            end
        end
    end

    assign hazard  = rd_found && wr_found && (raddr == waddr) && (wmask != '0) && !rst_i;
    assign rd_take = rd_found && !hazard && !rst_i;
    assign wr_take = wr_found && !rst_i;

    assign req_ready_o = (rd_take ? rd_grant : '0) | (wr_take ? wr_grant : '0);

    assign ram_re_o        = rd_take;
    assign ram_rclke_o     = rd_take;
    assign ram_raddr_o     = raddr;
    assign ram_we_o        = wr_take;
    assign ram_wclke_o     = wr_take;
    assign ram_waddr_o     = waddr;
    assign ram_wdata_o     = wdata;
    assign ram_wbytemask_o = wmask;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_pend_q    <= 1'b0;
            rd_id_q       <= '0;
            hazard_q      <= 1'b0;
            hazard_addr_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            rsp_pend_q <= rd_take;
            hazard_q   <= hazard;
            if (rd_take) rd_id_q <= rd_idx;
            if (hazard) begin
                hazard_addr_q <= raddr;
                if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_pend_q) rsp_valid_o[rd_id_q] = 1'b1;
    end

    assign rsp_rdata_o = ram_rdata_i;
    assign stall_cnt_o = stall_cnt_q;

endmodule
